// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int          SRAM_DW         = 16;
   localparam int          CNT_W           = 4;
   localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
   localparam int          DEF_WAIT_CYCLES = 3;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-access wait counter: counts 0..WAIT_CYCLES-1 while enabled, wraps on terminal count.
module sram_wait_counter
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tc_o = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: each 32-bit load/store becomes two 16-bit SRAM accesses, stalling via ready_o.
// Optional single-entry read buffer with write-through enabled by `define MEM_RD_BUF_EN.
module mem_stage_sram_ctrl
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          SRAM_AW     = 18,
   parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               mem_r_en_i,
   input  logic               mem_w_en_i,
   input  logic [31:0]        alu_res_i,
   input  logic [31:0]        val_rm_i,
   output logic               ready_o,
   output logic [31:0]        mem_rdata_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [SRAM_DW-1:0] sram_dq_out_o,
   input  logic [SRAM_DW-1:0] sram_dq_in_i,
   output logic               sram_dq_oe_o,
   output logic               sram_we_n_o
);

   localparam int IW = SRAM_AW - 1;

   state_e             state_q;
   logic               wr_q;
   logic [IW-1:0]      word_q;
   logic [SRAM_DW-1:0] whi_q;
   logic [31:0]        mem_rdata_q;
   logic [SRAM_AW-1:0] sram_addr_q;
   logic [SRAM_DW-1:0] sram_dq_out_q;
   logic               sram_dq_oe_q;
   logic               sram_we_n_q;

   logic [IW-1:0]      word_idx;
   logic               req;
   logic               busy;
   logic               cnt_tc;
   logic               rd_hit;
   logic [31:0]        hit_dat;

   // Wrapping subtract, then truncate so accesses alias modulo the SRAM size.
   assign word_idx = IW'((alu_res_i - BASE_ADDR) >> 2);
   assign req      = mem_r_en_i | mem_w_en_i;
   assign busy     = (state_q == LOW) || (state_q == HIGH);

   assign ready_o  = (state_q == DONE) || ((state_q == IDLE) && (!req || rd_hit));

   assign mem_rdata_o   = mem_rdata_q;
   assign sram_addr_o   = sram_addr_q;
   assign sram_dq_out_o = sram_dq_out_q;
   assign sram_dq_oe_o  = sram_dq_oe_q;
   assign sram_we_n_o   = sram_we_n_q;

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .clr_i (!busy),
      .en_i  (busy),
      .tc_o  (cnt_tc)
   );

`ifdef MEM_RD_BUF_EN
   logic          buf_vld_q;
   logic [IW-1:0] buf_tag_q;
   logic [31:0]   buf_dat_q;

   assign rd_hit  = (state_q == IDLE) && mem_r_en_i && !mem_w_en_i &&
                    buf_vld_q && (buf_tag_q == word_idx);
   assign hit_dat = buf_dat_q;

   // Fill on every completed read; halves of a matching write are mirrored as they finish.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_vld_q <= 1'b0;
         buf_tag_q <= '0;
         buf_dat_q <= '0;
      end else if (cnt_tc) begin
         if ((state_q == LOW) && wr_q && buf_vld_q && (buf_tag_q == word_q)) begin
            buf_dat_q[SRAM_DW-1:0] <= sram_dq_out_q;
         end
         if (state_q == HIGH) begin
            if (!wr_q) begin
               buf_vld_q <= 1'b1;
               buf_tag_q <= word_q;
               buf_dat_q <= {sram_dq_in_i, mem_rdata_q[SRAM_DW-1:0]};
            end else if (buf_vld_q && (buf_tag_q == word_q)) begin
               buf_dat_q[31:SRAM_DW] <= sram_dq_out_q;
            end
         end
      end
   end
`else
   assign rd_hit  = 1'b0;
   assign hit_dat = '0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         wr_q          <= 1'b0;
         word_q        <= '0;
         whi_q         <= '0;
         mem_rdata_q   <= '0;
         sram_addr_q   <= '0;
         sram_dq_out_q <= '0;
         sram_dq_oe_q  <= 1'b0;
         sram_we_n_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_hit) begin
                  mem_rdata_q <= hit_dat;
               end else if (req) begin
                  state_q     <= LOW;
                  wr_q        <= mem_w_en_i;
                  word_q      <= word_idx;
                  whi_q       <= val_rm_i[31:SRAM_DW];
                  sram_addr_q <= {word_idx, 1'b0};
                  if (mem_w_en_i) begin
                     sram_dq_out_q <= val_rm_i[SRAM_DW-1:0];
                     sram_dq_oe_q  <= 1'b1;
                     sram_we_n_q   <= 1'b0;
                  end
               end
            end
            LOW: begin
               if (cnt_tc) begin
                  state_q     <= HIGH;
                  sram_addr_q <= {word_q, 1'b1};
                  if (wr_q) begin
                     sram_dq_out_q <= whi_q;
                  end else begin
                     mem_rdata_q[SRAM_DW-1:0] <= sram_dq_in_i;
                  end
               end
            end
            HIGH: begin
               if (cnt_tc) begin
                  state_q      <= DONE;
                  sram_dq_oe_q <= 1'b0;
                  sram_we_n_q  <= 1'b1;
                  if (!wr_q) begin
                     mem_rdata_q[31:SRAM_DW] <= sram_dq_in_i;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl with a behavioural async SRAM.
module tb_mem_stage_sram_ctrl;

   localparam int          W    = 3;
   localparam logic [31:0] BASE = 32'd1024;
   localparam int          AW   = 18;
`ifdef MEM_RD_BUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          mem_r_en, mem_w_en;
   logic [31:0]   alu_res, val_rm;
   logic          ready;
   logic [31:0]   mem_rdata;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out, sram_dq_in;
   logic          sram_dq_oe, sram_we_n;

   always #5 clk = ~clk;

   mem_stage_sram_ctrl #(
      .BASE_ADDR  (BASE),
      .SRAM_AW    (AW),
      .WAIT_CYCLES(W)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .mem_r_en_i   (mem_r_en),
      .mem_w_en_i   (mem_w_en),
      .alu_res_i    (alu_res),
      .val_rm_i     (val_rm),
      .ready_o      (ready),
      .mem_rdata_o  (mem_rdata),
      .sram_addr_o  (sram_addr),
      .sram_dq_out_o(sram_dq_out),
      .sram_dq_in_i (sram_dq_in),
      .sram_dq_oe_o (sram_dq_oe),
      .sram_we_n_o  (sram_we_n)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   dat;
   } wr_t;

   int          n_vec = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;
   wr_t         exp_wr[$];
   logic [31:0] exp_rd[$];
   wr_t         mon_e;

   logic [15:0] sram    [logic [AW-1:0]];
   logic [31:0] ref_mem [logic [AW-2:0]];
   logic [31:0] rd_model = 32'h0;
   bit          bvld = 1'b0;
   logic [AW-2:0] btag = '0;

   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) sram[sram_addr] = sram_dq_out;
   end
   always @(negedge clk) begin
      sram_dq_in = sram.exists(sram_addr) ? sram[sram_addr] : 16'h0;
   end

   // Every write-strobe cycle must match the next expected {addr, data}.
   always @(negedge clk) begin
      if (mon_en && !sram_we_n) begin
         n_vec++;
         if (exp_wr.size() == 0) begin
            n_err++;
            $display("FAIL sram_write_unexpected: addr=%h dq=%h, required no write", sram_addr, sram_dq_out);
         end else begin
            mon_e = exp_wr.pop_front();
            if ({sram_addr, sram_dq_out, sram_dq_oe} !== {mon_e.addr, mon_e.dat, 1'b1}) begin
               n_err++;
               $display("FAIL sram_write: addr=%h dq=%h oe=%b, required addr=%h dq=%h oe=1",
                        sram_addr, sram_dq_out, sram_dq_oe, mon_e.addr, mon_e.dat);
            end
         end
      end
   end

   // Caller is at posedge+1; returns at posedge+1 with requests dropped.
   task automatic access(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, output int lat);
      logic [31:0]   off;
      logic [AW-2:0] idx;
      logic [AW-1:0] addr_before;
      logic [31:0]   exp;
      bit            hit;
      off = a - BASE;
      idx = off[AW:2];
      hit = BUF_EN && r && !w && bvld && (btag == idx);
      if (w) begin
         for (int k = 0; k < W; k++) exp_wr.push_back({{idx, 1'b0}, d[15:0]});
         for (int k = 0; k < W; k++) exp_wr.push_back({{idx, 1'b1}, d[31:16]});
         ref_mem[idx] = d;
      end else if (r) begin
         rd_model = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
         if (!hit) begin
            bvld = 1'b1;
            btag = idx;
         end
      end
      exp_rd.push_back(rd_model);
      addr_before = sram_addr;
      mem_w_en = w;
      mem_r_en = r;
      alu_res  = a;
      val_rm   = d;
      lat = 0;
      @(negedge clk);
      while (!ready && lat < 100) begin
         lat++;
         @(negedge clk);
      end
      n_vec++;
      if (lat != (hit ? 0 : 2 * W + 1)) begin
         n_err++;
         $display("FAIL latency a=%h: ready low %0d cycles, required %0d", a, lat, hit ? 0 : 2 * W + 1);
      end
      exp = exp_rd.pop_front();
      if (hit) begin
         @(posedge clk);
         #1;
      end
      n_vec++;
      if (mem_rdata !== exp) begin
         n_err++;
         $display("FAIL mem_rdata a=%h: got %h, required %h", a, mem_rdata, exp);
      end
      if (hit) begin
         n_vec++;
         if (sram_addr !== addr_before) begin
            n_err++;
            $display("FAIL hit_no_sram a=%h: sram_addr %h, required %h", a, sram_addr, addr_before);
         end
      end else begin
         @(posedge clk);
         #1;
      end
      mem_w_en = 1'b0;
      mem_r_en = 1'b0;
   endtask

   task automatic test_reset;
      rst_ni   = 1'b0;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      alu_res  = 32'h0;
      val_rm   = 32'h0;
      #12;
      n_vec++;
      if ({ready, sram_we_n, sram_dq_oe} !== 3'b110) begin
         n_err++;
         $display("FAIL reset_ctrl: ready/we_n/oe=%b, required 110", {ready, sram_we_n, sram_dq_oe});
      end
      n_vec++;
      if ({mem_rdata, sram_addr, sram_dq_out} !== '0) begin
         n_err++;
         $display("FAIL reset_data: rdata=%h addr=%h dq=%h, required all 0", mem_rdata, sram_addr, sram_dq_out);
      end
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read;
      int l;
      access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, l);
      access(1'b0, 1'b1, 32'd1028, 32'h0, l);
   endtask

   task automatic test_back_to_back;
      int l1, l2;
      access(1'b1, 1'b0, 32'd1032, 32'hA5A55A5A, l1);
      access(1'b0, 1'b1, 32'd1032, 32'h0, l2);
      n_vec++;
      if (l1 + l2 + 2 != 16) begin
         n_err++;
         $display("FAIL back_to_back: %0d cycles to second DONE, required 16", l1 + l2 + 2);
      end
   endtask

   task automatic test_both_set;
      int l;
      access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, l);
   endtask

   task automatic test_wrap;
      int l;
      access(1'b1, 1'b0, 32'd1020, 32'h0BADF00D, l);
      access(1'b0, 1'b1, 32'd1020, 32'h0, l);
   endtask

   task automatic test_read_buffer;
      int l;
      access(1'b0, 1'b1, 32'd1031, 32'h0, l);
      access(1'b0, 1'b1, 32'd1028, 32'h0, l);
      access(1'b1, 1'b0, 32'd1028, 32'h12345678, l);
      access(1'b0, 1'b1, 32'd1028, 32'h0, l);
   endtask

   task automatic test_reset_mid;
      int l;
      mon_en   = 1'b0;
      mem_w_en = 1'b1;
      alu_res  = 32'd1040;
      val_rm   = 32'h55AA33CC;
      repeat (5) @(posedge clk);
      #2;
      rst_ni   = 1'b0;
      mem_w_en = 1'b0;
      #1;
      n_vec++;
      if ({ready, sram_we_n, sram_dq_oe} !== 3'b110) begin
         n_err++;
         $display("FAIL reset_mid_ctrl: ready/we_n/oe=%b, required 110", {ready, sram_we_n, sram_dq_oe});
      end
      n_vec++;
      if (mem_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_mid_rdata: got %h, required 0", mem_rdata);
      end
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      exp_wr.delete();
      exp_rd.delete();
      rd_model = 32'h0;
      bvld     = 1'b0;
      mon_en   = 1'b1;
      @(posedge clk);
      #1;
      access(1'b0, 1'b1, 32'd1028, 32'h0, l);
   endtask

   initial begin
      test_reset;
      mon_en = 1'b1;
      test_write_read;
      test_back_to_back;
      test_both_set;
      test_wrap;
      test_read_buffer;
      test_reset_mid;
      repeat (2) @(posedge clk);
      n_vec++;
      if (exp_wr.size() != 0) begin
         n_err++;
         $display("FAIL write_drain: %0d expected SRAM write cycles never seen, required 0", exp_wr.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
